// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache.
// - icache_state_e : refill controller states
// - NOP_INSTR      : bubble word inserted by the pipe register while hit is low
// - default geometry plus helpers that derive index/tag widths from a geometry
package icache_pkg;

    typedef enum logic {
        IDLE,
        REFILL
    } icache_state_e;

    // add $0,$0,$0
    localparam logic [31:0] NOP_INSTR = 32'd32;

    localparam int unsigned LINES_DEF  = 16;
    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned IDX_W_DEF  = $clog2(LINES_DEF);
    localparam int unsigned TAG_W_DEF  = ADDR_W_DEF - 2 - IDX_W_DEF;

    function automatic int unsigned idx_width(input int unsigned lines);
        return $clog2(lines);
    endfunction

    function automatic int unsigned tag_width(input int unsigned lines,
                                              input int unsigned addr_w);
        return addr_w - 2 - $clog2(lines);
    endfunction

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data arrays for the direct-mapped instruction cache.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset (clears valid bits only)
//   flush_i              invalidate every line on this edge; blocks a same-edge write
//   we_i, widx_i,
//   wtag_i, wdata_i      synchronous write port
//   ridx_i               asynchronous read index
//   rvalid_o, rtag_o,
//   rdata_o              read data for ridx_i
module icache_line_store #(
    parameter int unsigned LINES  = 16,
    parameter int unsigned IDX_W  = 4,
    parameter int unsigned TAG_W  = 26,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  widx_i,
    input  logic [TAG_W-1:0]  wtag_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  ridx_i,
    output logic              rvalid_o,
    output logic [TAG_W-1:0]  rtag_o,
    output logic [DATA_W-1:0] rdata_o
);

    logic [LINES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES];

    always_comb begin
        valid_d = valid_q;
        if (flush_i) begin
            valid_d = '0;
        end else if (we_i) begin
            valid_d[widx_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Payload arrays carry no reset; the valid bits gate every use.
    always_ff @(posedge clk_i) begin
        if (we_i && !flush_i) begin
            tag_q[widx_i]  <= wtag_i;
            data_q[widx_i] <= wdata_i;
        end
    end

    assign rvalid_o = valid_q[ridx_i];
    assign rtag_o   = tag_q[ridx_i];
    assign rdata_o  = data_q[ridx_i];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped, one-word-per-line instruction cache with a req/ack refill port.
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   pc                  fetch byte address (bits [1:0] ignored)
//   flush               invalidate all lines on this edge
//   hit, instruction    combinational lookup result (instruction is 0 on a miss)
//   mem_req, mem_addr   refill request and word-aligned address, held until ack
//   mem_ack, mem_data   refill acknowledge and returned word (same cycle)
module instruction_cache
    import icache_pkg::*;
#(
    parameter int unsigned LINES  = LINES_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    input  logic              flush,
    output logic              hit,
    output logic [ADDR_W-1:0] instruction,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [ADDR_W-1:0] mem_data
);

    localparam int unsigned IdxW = idx_width(LINES);
    localparam int unsigned TagW = tag_width(LINES, ADDR_W);

    icache_state_e     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              discard_q, discard_d;
    logic              line_we;

    logic [IdxW-1:0]   pc_idx;
    logic [TagW-1:0]   pc_tag;
    logic              rd_valid;
    logic [TagW-1:0]   rd_tag;
    logic [ADDR_W-1:0] rd_data;
    logic              unused_pc_lsb;

    assign pc_idx        = pc[2+IdxW-1:2];
    assign pc_tag        = pc[ADDR_W-1:2+IdxW];
    assign unused_pc_lsb = ^pc[1:0];

    icache_line_store #(
        .LINES  (LINES),
        .IDX_W  (IdxW),
        .TAG_W  (TagW),
        .DATA_W (ADDR_W)
    ) u_store (
        .clk_i    (clk),
        .rst_ni   (reset),
        .flush_i  (flush),
        .we_i     (line_we),
        .widx_i   (addr_q[2+IdxW-1:2]),
        .wtag_i   (addr_q[ADDR_W-1:2+IdxW]),
        .wdata_i  (mem_data),
        .ridx_i   (pc_idx),
        .rvalid_o (rd_valid),
        .rtag_o   (rd_tag),
        .rdata_o  (rd_data)
    );

    // Lookups are masked during refill so the old line contents are never seen.
    assign hit         = (state_q == IDLE) && rd_valid && (rd_tag == pc_tag);
    assign instruction = hit ? rd_data : '0;
    assign mem_req     = (state_q == REFILL);
    assign mem_addr    = addr_q;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        discard_d = discard_q;
        line_we   = 1'b0;
        case (state_q)
            IDLE: begin
                // A flush on a missing cycle takes priority; no refill starts.
                if (!hit && !flush) begin
                    state_d   = REFILL;
                    addr_d    = {pc[ADDR_W-1:2], 2'b00};
                    discard_d = 1'b0;
                end
            end
            REFILL: begin
                if (flush) begin
                    discard_d = 1'b1;
                end
                if (mem_ack) begin
                    // Returned word is dropped if any flush hit this refill.
                    line_we   = !discard_q && !flush;
                    discard_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            discard_q <= discard_d;
        end
    end

endmodule

// File: doc/instruction_cache.md
# instruction_cache

Direct-mapped, single-word-per-line instruction cache sitting between the program counter and the fetch/decode pipeline register. It answers each fetch address with `hit` and `instruction` in the same cycle. On a miss it runs a request/acknowledge refill from instruction memory. While `hit` is low the downstream pipe register inserts a nop, so the refill stalls decode without extra control.

## Interface
Parameters:
- `LINES`, 16, number of cache lines; power of two, ≥2.
- `ADDR_W`, 32, address and instruction width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `pc`  in  ADDR_W  fetch byte address; bits [1:0] ignored.
- `flush`  in  1  invalidate all lines; sampled on the clock edge.
- `hit`  out  1  `pc` is present and valid; combinational.
- `instruction`  out  ADDR_W  cached word when `hit`=1, else 0.
- `mem_req`  out  1  refill request to instruction memory.
- `mem_addr`  out  ADDR_W  word-aligned refill address, stable while `mem_req`=1.
- `mem_ack`  in  1  memory acknowledge; `mem_data` is valid in the same cycle.
- `mem_data`  in  ADDR_W  refill word.

## Operation
- Address split:
  - index = `pc[2+IDX-1:2]`, where IDX = log2(LINES).
  - tag = `pc[ADDR_W-1:2+IDX]`.
- Per line: valid bit, tag, data word. Only the valid bits are reset.
- Lookup: `hit` = state is IDLE, the line is valid, and the tag matches. `hit` is forced to 0 in REFILL.

State machine:
- IDLE
  - On a miss (not `hit`, `reset` high, `flush` low): latch `{pc[ADDR_W-1:2], 2'b00}` into `mem_addr` and go to REFILL.
  - On a hit: stay in IDLE.
- REFILL
  - `mem_req`=1 and `mem_addr` is held.
  - On an edge with `mem_ack`=1: write tag, data and valid=1 into the indexed line, unless the discard flag is set. Clear the discard flag and return to IDLE.
  - `pc` changes during REFILL are ignored. The latched address is always completed, then the current `pc` is looked up again in IDLE.

Flush:
- `flush`=1 on an edge clears all valid bits.
- In REFILL, `flush` also sets the discard flag. The handshake still completes, but the returned word is dropped.
- `flush` in IDLE while missing: the flush wins and no refill starts that cycle.
- `flush` on the same edge as `mem_ack`: the line is not written.

Handshake rules:
- `mem_req` rises only on entry to REFILL.
- `mem_req` falls on the edge where `mem_ack` is sampled high.
- `mem_ack` while `mem_req`=0 is ignored.

Reset (asynchronous, `reset`=0), including mid-refill:
- state = IDLE, `mem_req`=0, `mem_addr`=0, discard flag = 0, all valid bits = 0.
- Consequently `hit`=0 and `instruction`=0.

## Timing
- Hit latency: 0 cycles (combinational from `pc` and the arrays).
- Miss, for a miss presented in cycle 0:
  - `mem_req`=1 from cycle 1.
  - If `mem_ack` is sampled at the end of cycle k (k ≥ 1), `hit`=1 for that address from cycle k+1.
  - Minimum miss penalty is 2 cycles of `hit`=0.
- The refilled line is readable on the cycle after the write edge. There is no same-cycle bypass of `mem_data`.
- A line is overwritten only at the `mem_ack` edge. The previous contents stay valid until then, but are unreachable because `hit` is forced to 0 during REFILL.

## Structure
- Shared package `icache_pkg`:
  - state enum {IDLE, REFILL}.
  - `NOP_INSTR` = 32 (`add $0,$0,$0`), used by downstream stages.
  - localparams for IDX and tag width, derived from `LINES` and `ADDR_W`.
- One sub-module, `icache_line_store`:
  - holds the valid/tag/data arrays.
  - one synchronous write port, asynchronous read by index.
  - flush-all input and asynchronous valid clear.
- The top level holds the FSM, the latched address, the discard flag and the hit compare.

## Test plan
Defaults: `LINES`=16.
1. **Cold miss.** Release reset; `pc`=0x0000_0040.
   - Cycle 0: `hit`=0.
   - Cycle 1: `mem_req`=1, `mem_addr`=0x40.
   - Ack with `mem_data`=0x2002_0005 in cycle 3 → cycle 4: `hit`=1, `instruction`=0x2002_0005, `mem_req`=0.
2. **Conflict.** After scenario 1, `pc`=0x0000_0080 (index 0, tag 2).
   - Miss and refill with 0xDEAD_BEEF → `hit`=1 with 0xDEAD_BEEF.
   - Returning to `pc`=0x40 misses again.
3. **Minimum penalty and pc change mid-refill.**
   - `mem_ack` high in the first REFILL cycle → exactly 2 cycles of `hit`=0.
   - In a separate refill, `pc` changes from 0x40 to 0x44 during REFILL → `mem_addr` stays 0x40; after the ack, 0x44 misses and issues `mem_addr`=0x44.
4. **Flush during REFILL.** Assert `flush` one cycle before `mem_ack`.
   - Handshake completes and `mem_req` drops.
   - `pc`=0x40 then misses again; no stale hit.
5. **Reset mid-refill.** Pull `reset` low while `mem_req`=1.
   - Immediately (no clock edge): `mem_req`=0, `mem_addr`=0, `hit`=0.
   - After release, a previously cached address misses.
6. **Stray ack.** `mem_ack`=1 while in IDLE with a hit.
   - No state change; cache contents unchanged.
